// File: rtl/seg7_pkg.sv
// Shared types, digit count and the hex-to-segment lookup for the 8-digit scan driver.
// Segment patterns are stored active-low in {g,f,e,d,c,b,a} order.
package seg7_pkg;

  localparam int DIGITS = 8;
  localparam int NIB_W  = 4;
  localparam int DATA_W = DIGITS * NIB_W;

  typedef logic [NIB_W-1:0] nibble_t;
  typedef logic [6:0]       seg_t;

  localparam seg_t SEG_ALL_OFF_N = 7'h7F;

  localparam seg_t SEG7_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic seg_t seg7_decode(input nibble_t nib);
    return SEG7_LUT[nib];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-segment decoder; output is always the active-low pattern,
// the caller applies board polarity.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = seg7_decode(nibble_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit hex display driver: per-digit time slots with leading dead time,
// once-per-frame shadow latch of the displayed word, optional leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV    = 100000,
  parameter int BLANK_CYC   = 1000,
  parameter bit AN_ACT_LOW  = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic        clk_100MHz,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] data,
  input  logic [7:0]  dp_mask,
  input  logic        blank_lz,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = $clog2(DIGITS);

  localparam logic [CW-1:0]     SLOT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]     BLANK_END  = CW'(BLANK_CYC);
  localparam logic [DW-1:0]     DIGIT_LAST = DW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF     = AN_ACT_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [6:0]        SEG_OFF    = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_OFF     = SEG_ACT_LOW;

  generate
    if (BLANK_CYC >= SCAN_DIV) begin : g_bad_cfg
      $error("seg7_scan_driver: BLANK_CYC must be smaller than SCAN_DIV");
    end
  endgenerate

  logic [CW-1:0]     slot_cnt_q, slot_cnt_d;
  logic [DW-1:0]     digit_q, digit_d;
  logic              start_q, start_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DIGITS-1:0] dp_shadow_q, dp_shadow_d;
  logic              lz_shadow_q, lz_shadow_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              frame_tick_q, frame_tick_d;

  logic              load_shadow;
  logic [DIGITS-1:0] upper_zero;
  logic              blank_digit;
  logic              lit;
  logic [3:0]        cur_nibble;
  logic [6:0]        dec_seg_n;
  logic [6:0]        seg_n;
  logic              dp_n;
  logic [DIGITS-1:0] digit_onehot;

  // The cycle right after reset release only loads the shadow; counters hold at
  // slot 0 / digit 0 so the first displayed frame already uses the fresh word.
  always_comb begin
    slot_cnt_d  = slot_cnt_q;
    digit_d     = digit_q;
    start_d     = 1'b0;
    load_shadow = start_q;
    if (!start_q) begin
      if (slot_cnt_q == SLOT_LAST) begin
        slot_cnt_d = '0;
        if (digit_q == DIGIT_LAST) begin
          digit_d     = '0;
          load_shadow = 1'b1;
        end else begin
          digit_d = digit_q + DW'(1);
        end
      end else begin
        slot_cnt_d = slot_cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    shadow_d    = shadow_q;
    dp_shadow_d = dp_shadow_q;
    lz_shadow_d = lz_shadow_q;
    if (load_shadow) begin
      shadow_d    = data;
      dp_shadow_d = dp_mask;
      lz_shadow_d = blank_lz;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_lz
      assign upper_zero[gi] = (shadow_q[DATA_W-1:NIB_W*gi] == '0);
    end
  endgenerate

  assign blank_digit  = lz_shadow_q && (digit_q != '0) && upper_zero[digit_q];
  assign cur_nibble   = shadow_q[{digit_q, 2'b00} +: NIB_W];
  assign digit_onehot = DIGITS'(1) << digit_q;

  hex_to_seg7 u_dec (
    .nibble_i (cur_nibble),
    .seg_n_o  (dec_seg_n)
  );

  always_comb begin
    seg_n        = blank_digit ? SEG_ALL_OFF_N : dec_seg_n;
    dp_n         = ~dp_shadow_q[digit_q];
    lit          = en && (slot_cnt_q >= BLANK_END) && !blank_digit;
    an_d         = lit ? (AN_ACT_LOW ? ~digit_onehot : digit_onehot) : AN_OFF;
    seg_d        = SEG_ACT_LOW ? seg_n : ~seg_n;
    dp_d         = SEG_ACT_LOW ? dp_n : ~dp_n;
    frame_tick_d = !start_q && (slot_cnt_q == '0) && (digit_q == '0);
    if (start_q) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = DP_OFF;
    end
  end

  always_ff @(posedge clk_100MHz or negedge rst) begin
    if (!rst) begin
      slot_cnt_q   <= '0;
      digit_q      <= '0;
      start_q      <= 1'b1;
      shadow_q     <= '0;
      dp_shadow_q  <= '0;
      lz_shadow_q  <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      digit_q      <= digit_d;
      start_q      <= start_d;
      shadow_q     <= shadow_d;
      dp_shadow_q  <= dp_shadow_d;
      lz_shadow_q  <= lz_shadow_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized scoreboard bench: each frame's expected digit patterns are queued when the
// word is applied and checked cycle by cycle once the matching frame_tick appears.
module tb_seg7_scan_driver;

  localparam int SD  = 16;
  localparam int BC  = 2;
  localparam int NFR = 14;
  localparam int FRAME = SD * 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        blank_lz = 1'b0;
  logic [31:0] data = '0;
  logic [7:0]  dp_mask = '0;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;
  logic        en_smp = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [55:0] seg;
    logic [7:0]  blank;
    logic [7:0]  dpn;
  } rec_t;

  rec_t exp_q[$];

  logic [31:0] dir_d  [7] = '{32'hDEADBEEF, 32'h00000000, 32'h000000A0, 32'h00000000,
                              32'h12345678, 32'h87654321, 32'h00C0FFEE};
  logic [7:0]  dir_dp [7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00};
  logic        dir_lz [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic        dir_en [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  // What the DUT sampled for en at the edge that produced the current outputs.
  always @(posedge clk) en_smp <= en;

  seg7_scan_driver #(
    .SCAN_DIV    (SD),
    .BLANK_CYC   (BC),
    .AN_ACT_LOW  (1'b1),
    .SEG_ACT_LOW (1'b1)
  ) dut (
    .clk_100MHz (clk),
    .rst        (rst),
    .en         (en),
    .data       (data),
    .dp_mask    (dp_mask),
    .blank_lz   (blank_lz),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic rec_t model(input logic [31:0] d, input logic [7:0] m, input logic lz);
    rec_t r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] up;
      up = d >> (4 * i);
      r.blank[i] = lz && (i > 0) && (up == 0);
      r.seg[7*i +: 7] = r.blank[i] ? 7'h7F : seg_ref(up[3:0]);
      r.dpn[i] = ~m[i];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic run_monitor(input int nframes);
    rec_t        rec;
    logic [7:0]  exp_an;
    int          d;
    int          o;
    for (int f = 0; f < nframes; f++) begin
      int w = 0;
      if (f > 0) check($sformatf("tick_period_f%0d", f), {31'd0, frame_tick}, 32'd1);
      while (!frame_tick && w < 3 * FRAME) begin
        @(negedge clk);
        w++;
      end
      if (!frame_tick) begin
        check("tick_timeout", 32'd0, 32'd1);
        return;
      end
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd0, 32'd1);
        return;
      end
      rec = exp_q.pop_front();
      for (int k = 0; k < FRAME; k++) begin
        d = k / SD;
        o = k % SD;
        exp_an = (o < BC || !en_smp || rec.blank[d]) ? 8'hFF : ~(8'd1 << d);
        check($sformatf("f%0d_dig%0d_slot%0d {an,seg,dp,tick}", f, d, o),
              {15'd0, an, seg, dp, frame_tick},
              {15'd0, exp_an, rec.seg[7*d +: 7], rec.dpn[d], (k == 0)});
        @(negedge clk);
      end
      $display("frame %0d checked: seg=%h blank=%h dpn=%h", f, rec.seg, rec.blank, rec.dpn);
    end
  endtask

  task automatic run_stim(input int niters);
    for (int j = 0; j < niters; j++) begin
      int          w = 0;
      logic [31:0] nd;
      logic [7:0]  ndp;
      logic        nlz;
      logic        nen;
      do begin
        @(negedge clk);
        w++;
      end while (!frame_tick && w < 3 * FRAME);
      if (!frame_tick) begin
        check("stim_tick_timeout", 32'd0, 32'd1);
        return;
      end
      if (j < 7) begin
        nd = dir_d[j]; ndp = dir_dp[j]; nlz = dir_lz[j]; nen = dir_en[j];
      end else begin
        nd  = $urandom >> (4 * $urandom_range(0, 8));
        ndp = 8'($urandom);
        nlz = 1'($urandom_range(0, 1));
        nen = ($urandom_range(0, 3) != 0);
      end
      // Mid-frame junk: must never reach the display of the frame in progress.
      data = $urandom; dp_mask = 8'($urandom); blank_lz = 1'($urandom_range(0, 1)); en = nen;
      repeat ($urandom_range(30, 100)) @(negedge clk);
      data = nd; dp_mask = ndp; blank_lz = nlz;
      if (j >= 7) en = ($urandom_range(0, 3) != 0);
      exp_q.push_back(model(nd, ndp, nlz));
    end
  endtask

  initial begin
    int w;
    rst = 1'b0; data = 32'h12345678; dp_mask = 8'h00; blank_lz = 1'b0; en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs {an,seg,dp,tick}", {15'd0, an, seg, dp, frame_tick},
            {15'd0, 8'hFF, 7'h7F, 1'b1, 1'b0});
    end
    exp_q.push_back(model(data, dp_mask, blank_lz));
    rst = 1'b1;
    fork
      run_stim(NFR - 1);
      run_monitor(NFR);
    join

    data = 32'hFFFFFFFF; dp_mask = 8'h00; blank_lz = 1'b0; en = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!frame_tick && w < 3 * FRAME);
    check("pre_areset_tick", {31'd0, frame_tick}, 32'd1);
    repeat (5 * SD + 9) @(negedge clk);
    check("pre_areset_an_digit5", {24'd0, an}, {24'd0, 8'hDF});
    #2 rst = 1'b0;
    #1;
    check("areset_async {an,seg,dp,tick}", {15'd0, an, seg, dp, frame_tick},
          {15'd0, 8'hFF, 7'h7F, 1'b1, 1'b0});
    @(negedge clk);
    check("areset_held {an,seg,dp,tick}", {15'd0, an, seg, dp, frame_tick},
          {15'd0, 8'hFF, 7'h7F, 1'b1, 1'b0});
    data = 32'h0000B00C; dp_mask = 8'h81; blank_lz = 1'b1; en = 1'b1;
    exp_q.delete();
    exp_q.push_back(model(data, dp_mask, blank_lz));
    exp_q.push_back(model(data, dp_mask, blank_lz));
    rst = 1'b1;
    run_monitor(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
